// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_pkg
// Brief    : Shared function-select encodings and select-width helper for the
//            register bank.
// Revision : 1.0
// ============================================================================
package reg_bank_pkg;

  localparam logic [2:0] FS_CLR  = 3'b000;
  localparam logic [2:0] FS_LOAD = 3'b001;
  localparam logic [2:0] FS_INC  = 3'b010;
  localparam logic [2:0] FS_DEC  = 3'b011;
  localparam logic [2:0] FS_SHL  = 3'b100;
  localparam logic [2:0] FS_SHR  = 3'b101;
  localparam logic [2:0] FS_ROTL = 3'b110;
  localparam logic [2:0] FS_HOLD = 3'b111;

  // A select port always needs at least one bit, even for a 2-entry bank.
  function automatic int sel_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_cell.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_cell
// Brief    : One N-bit register applying the shared FunSel operation when
//            enabled; flags inc-at-all-ones / dec-at-zero.
// Revision : 1.0
// ============================================================================
module reg_bank_cell
  import reg_bank_pkg::*;
#(
  parameter int           N         = 8,
  parameter int           SATURATE  = 0,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [2:0]   i_fun_sel,
  input  logic [N-1:0] i_din,
  output logic [N-1:0] o_q,
  output logic         o_wrap_evt
);

  localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] r_q;
  logic [N-1:0] w_next;
  logic         w_all1;
  logic         w_zero;

  assign w_all1 = &r_q;
  assign w_zero = ~|r_q;

  always_comb begin
    w_next = r_q;
    case (i_fun_sel)
      FS_CLR:  w_next = '0;
      FS_LOAD: w_next = i_din;
      FS_INC:  w_next = (w_all1 && SATURATE != 0) ? r_q : r_q + c_one;
      FS_DEC:  w_next = (w_zero && SATURATE != 0) ? r_q : r_q - c_one;
      FS_SHL:  w_next = {r_q[N-2:0], 1'b0};
      FS_SHR:  w_next = {1'b0, r_q[N-1:1]};
      FS_ROTL: w_next = {r_q[N-2:0], r_q[N-1]};
      default: w_next = r_q;
    endcase
  end

  // Boundary crossing is reported whether the value wrapped or was clamped.
  assign o_wrap_evt = i_en && ((i_fun_sel == FS_INC && w_all1) ||
                               (i_fun_sel == FS_DEC && w_zero));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RESET_VAL;
    end else if (i_en) begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/reg_bank_fs.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_fs
// Brief    : DEPTH x N register bank with shared 3-bit function select, two
//            combinational read ports and a sticky wrap/saturation flag.
// Revision : 1.0
// ============================================================================
module reg_bank_fs
  import reg_bank_pkg::*;
#(
  parameter int           N         = 8,
  parameter int           DEPTH     = 4,
  parameter int           SATURATE  = 0,
  parameter logic [N-1:0] RESET_VAL = '0,
  localparam int          c_sel_w   = sel_width(DEPTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DEPTH-1:0]   E,
  input  logic [2:0]         FunSel,
  input  logic [N-1:0]       I,
  input  logic [c_sel_w-1:0] OutASel,
  input  logic [c_sel_w-1:0] OutBSel,
  output logic [N-1:0]       OutA,
  output logic [N-1:0]       OutB,
  output logic               ZeroA,
  output logic               WrapFlag,
  input  logic               FlagClr
);

  localparam int c_slots = 1 << c_sel_w;

  // Unused select codes map to zero-tied slots so out-of-range reads return 0.
  logic [N-1:0]     w_q [c_slots];
  logic [DEPTH-1:0] w_wrap;
  logic             r_wrap_flag;

  for (genvar k = 0; k < DEPTH; k++) begin : g_cell
    reg_bank_cell #(
      .N         (N),
      .SATURATE  (SATURATE),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk        (CLK),
      .rst        (RST),
      .i_en       (E[k]),
      .i_fun_sel  (FunSel),
      .i_din      (I),
      .o_q        (w_q[k]),
      .o_wrap_evt (w_wrap[k])
    );
  end

  for (genvar k = DEPTH; k < c_slots; k++) begin : g_pad
    assign w_q[k] = '0;
  end

  // A wrap event in the same cycle as FlagClr keeps the flag set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wrap_flag <= 1'b0;
    end else if (|w_wrap) begin
      r_wrap_flag <= 1'b1;
    end else if (FlagClr) begin
      r_wrap_flag <= 1'b0;
    end
  end

  assign OutA     = w_q[OutASel];
  assign OutB     = w_q[OutBSel];
  assign ZeroA    = (OutA == '0);
  assign WrapFlag = r_wrap_flag;

endmodule
`default_nettype wire

// File: doc/reg_bank_fs.md
Name: reg_bank_fs

Overview:
- Parametrised bank of DEPTH registers, each N bits wide, sharing one function-select bus.
- Successor to the single n-bit register: extends FunSel from 2 to 3 bits, adding shift and rotate operations.
- Adds per-register write enables, two combinational read ports, optional saturating arithmetic, and a sticky wrap/saturation flag.
- Sits between the ALU/bus and the datapath as a general-purpose register file.

Parameters:
- N, 8, register width in bits (>=2).
- DEPTH, 4, number of registers (2..16).
- SATURATE, 0, 0: inc/dec wrap modulo 2^N; 1: inc/dec clamp at all-ones/zero.
- RESET_VAL, 0, N-bit value loaded into every register on reset.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- E  in  DEPTH  write-enable mask; bit k enables register k.
- FunSel  in  3  operation applied to every enabled register.
- I  in  N  load data.
- OutASel  in  clog2(DEPTH)  read port A select.
- OutBSel  in  clog2(DEPTH)  read port B select.
- OutA  out  N  contents of register OutASel (combinational).
- OutB  out  N  contents of register OutBSel (combinational).
- ZeroA  out  1  1 when OutA == 0 (combinational).
- WrapFlag  out  1  sticky flag for inc/dec overflow or clamping.
- FlagClr  in  1  clears WrapFlag.

Behaviour:
- One clock, CLK; reset is synchronous and active-high on RST. On a rising CLK edge with RST=1:
  - every register <= RESET_VAL; WrapFlag <= 0.
  - E, FunSel and FlagClr are ignored.
- On a rising CLK edge with RST=0, each register k with E[k]=1 updates per FunSel:
  - 000 clear: 0.
  - 001 load: I.
  - 010 inc: +1.
  - 011 dec: -1.
  - 100 shl: shift left by 1, LSB fill 0.
  - 101 shr: logical shift right by 1, MSB fill 0.
  - 110 rotl: rotate left by 1.
  - 111 hold: no change.
- Registers with E[k]=0 hold their value.
- Latency:
  - Writes are visible on OutA/OutB one cycle after the edge.
  - Reads are combinational: no read-during-write bypass, so a read in the write cycle returns the old value.
- Arithmetic is N bits unsigned.
  - SATURATE=0: all-ones+1 -> 0; 0-1 -> all-ones.
  - SATURATE=1: all-ones+1 -> all-ones; 0-1 -> 0.
- Wrap event: an enabled register receives inc while holding all-ones, or dec while holding 0 (both SATURATE modes).
  - Wrap event on any register sets WrapFlag <= 1 at that edge.
  - FlagClr=1 with no wrap event that cycle: WrapFlag <= 0.
  - FlagClr=1 and a wrap event in the same cycle: set wins, WrapFlag=1.
  - RST overrides both.
- Shifts and rotates never affect WrapFlag.
- E=0 (all bits): bank fully holds regardless of FunSel; FlagClr still acts.
- Several E bits set: all selected registers apply the same FunSel independently from their own current values.
- Out-of-range selects (OutASel/OutBSel >= DEPTH): the corresponding output is 0, and ZeroA=1 when OutASel is out of range.
- Reset asserted mid-sequence (e.g. during an inc chain) discards the pending op; the next cycle resumes from RESET_VAL.

Decomposition:
- Shared package reg_bank_pkg:
  - FunSel localparams FS_CLR, FS_LOAD, FS_INC, FS_DEC, FS_SHL, FS_SHR, FS_ROTL, FS_HOLD (3-bit).
  - Helper for clog2 select width.
- One natural sub-module, reg_bank_cell, instantiated DEPTH times via generate:
  - Single N-bit register with E, FunSel, I and SATURATE/RESET_VAL.
  - Outputs its value and a 1-bit wrap_evt pulse.
- Top level: OR-reduces wrap_evt into WrapFlag and implements the two read muxes.

Test Plan (N=8, DEPTH=4, RESET_VAL=0 unless stated):
- Reset then load: RST=1 one cycle, then E=0001, FunSel=001, I=0xAA -> next cycle OutA(sel 0)=0xAA, regs 1-3 = 0x00, ZeroA=0, WrapFlag=0.
- Wrap, SATURATE=0: load reg2=0xFF, inc with E=0100 -> reg2=0x00, WrapFlag=1; FlagClr=1 one cycle -> WrapFlag=0; dec reg2 -> 0xFF, WrapFlag=1.
- Saturate, SATURATE=1: reg1=0xFE, inc twice -> 0xFF, then 0xFF with WrapFlag=1 on the second inc only; reg3=0x00 dec -> stays 0x00, flag set.
- Shift/rotate: reg0=0x81.
  - rotl -> 0x03; shl -> 0x06; shr -> 0x03.
  - E=0000 with FunSel=010 -> all regs unchanged; WrapFlag stays 0 throughout.
- Multi-enable and simultaneous events: E=1111, load 0xFF, then inc with FlagClr=1 same cycle -> all regs 0x00, WrapFlag=1 (set beats clear).
- Reset mid-operation and read timing:
  - RESET_VAL=0x10: inc chain on reg0 with RST pulsed at cycle 3 -> reg0=0x10 the next cycle, WrapFlag=0.
  - Write reg1 with OutBSel=1 in the same cycle -> OutB shows the old value until the following cycle.
